mnist_frame_reader: RTL

Read-side controller for the 28x28x8-bit MNIST frame RAM. On a start pulse it drives the RAM read port (synchronous read, 1-cycle latency) through all 784 addresses in raster order. It delivers the pixels as a valid/ready stream with row/col/last sideband to the downstream consumer (CNN input or VGA line fetch). Full backpressure is supported with no dropped or duplicated pixels.

---
 rtl/mnist_frame_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mnist_frame_reader.sv
// rtl/mnist_frame_reader.sv - raster-order read controller for the 28x28 MNIST frame RAM
//
// Reads every pixel of the frame RAM in raster order after a start pulse and
// presents the pixels as a valid/ready stream with row/col/last sideband.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   start                 begin one frame read (sampled only while idle)
//   busy, done            frame in progress / one-cycle end-of-frame pulse
//   ram_addr, ram_dout    RAM read port (synchronous read, 1-cycle latency)
//   m_valid, m_ready      stream handshake
//   m_data, m_row, m_col  pixel value and its coordinates
//   m_last                marks the final pixel of the frame
module mnist_frame_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_ROWS   = 28,
   parameter int IMG_COLS   = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [9:0]            ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [4:0]            m_row,
   output logic [4:0]            m_col,
   output logic                  m_last
);

   localparam int IMG_SIZE = IMG_ROWS * IMG_COLS;
   localparam logic [9:0] SIZE_A   = 10'(IMG_SIZE);
   localparam logic [9:0] LAST_A   = 10'(IMG_SIZE - 1);
   localparam logic [4:0] LAST_COL = 5'(IMG_COLS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state;
   logic [9:0]            rd_ptr;
   logic [9:0]            out_cnt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_idx;
   logic                  rd_idx;
   logic [1:0]            fifo_count;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [2:0]            credit;

   always_comb begin
      m_valid = (fifo_count != 2'd0);
      m_data  = fifo_mem[rd_idx];
      m_last  = (out_cnt == LAST_A);
      pop     = m_valid && m_ready;
      push    = inflight;
      // Slots already claimed (stored + in flight) after this cycle's pop;
      // a read may only issue if a FIFO entry is guaranteed for its data.
      credit  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
      issue   = (state == RUN) && (rd_ptr < SIZE_A) && (credit < 3'd2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         rd_ptr      <= '0;
         ram_addr    <= '0;
         inflight    <= 1'b0;
         out_cnt     <= '0;
         m_row       <= '0;
         m_col       <= '0;
         fifo_count  <= '0;
         wr_idx      <= 1'b0;
         rd_idx      <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;

         if (push) begin
            fifo_mem[wr_idx] <= ram_dout;
            wr_idx           <= ~wr_idx;
         end
         if (pop)
            rd_idx <= ~rd_idx;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};

         // ram_addr runs one ahead of the issued address but parks on the
         // final pixel once it has been read.
         if (issue) begin
            rd_ptr <= rd_ptr + 10'd1;
            if (rd_ptr != LAST_A)
               ram_addr <= rd_ptr + 10'd1;
         end

         if (pop) begin
            if (m_last) begin
               out_cnt <= '0;
               m_row   <= '0;
               m_col   <= '0;
            end else begin
               out_cnt <= out_cnt + 10'd1;
               if (m_col == LAST_COL) begin
                  m_col <= '0;
                  m_row <= m_row + 5'd1;
               end else begin
                  m_col <= m_col + 5'd1;
               end
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  rd_ptr   <= '0;
                  ram_addr <= '0;
                  out_cnt  <= '0;
                  m_row    <= '0;
                  m_col    <= '0;
               end
            end
            RUN: begin
               if (pop && m_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
